// File: rtl/ff_bank_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ff_bank_arbiter                                                  |
// | Brief   : Round-robin write arbiter and preset sequencer for a shared      |
// |           WIDTH-bit register bank.                                         |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module ff_bank_arbiter #(
    parameter  int WIDTH = 8,
    parameter  int NREQ  = 4,
    localparam int PW    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  R_n,
    input  logic                  set_req,
    output logic                  set_ack,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] din,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      Q,
    output logic [PW-1:0]         owner,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTING = 2'd1,
        S_GRANT   = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [NREQ-1:0]  r_gnt;
    logic             r_set_ack;
    logic [PW-1:0]    r_owner;
    logic [PW-1:0]    r_ptr;

    state_t           w_state_nx;
    logic [WIDTH-1:0] w_q_nx;
    logic [NREQ-1:0]  w_gnt_nx;
    logic             w_set_ack_nx;
    logic [PW-1:0]    w_owner_nx;
    logic [PW-1:0]    w_ptr_nx;
    logic             w_found;
    logic [PW-1:0]    w_win;
    logic [WIDTH-1:0] w_din [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_din
            assign w_din[gi] = din[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Index base+off folded back into 0..NREQ-1 (NREQ need not be a power of 2).
    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return PW'(s);
    endfunction

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req[wrap_idx(r_ptr, i)]) begin
                w_found = 1'b1;
                w_win   = wrap_idx(r_ptr, i);
            end
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_q_nx       = r_q;
        w_gnt_nx     = '0;
        w_set_ack_nx = 1'b0;
        w_owner_nx   = r_owner;
        w_ptr_nx     = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (set_req) begin
                    w_state_nx = S_SETTING;
                end else if (w_found) begin
                    w_state_nx        = S_GRANT;
                    w_gnt_nx[w_win]   = 1'b1;
                    w_owner_nx        = w_win;
                end
            end
            S_SETTING: begin
                w_state_nx   = S_IDLE;
                w_q_nx       = '1;
                w_set_ack_nx = 1'b1;
            end
            S_GRANT: begin
                w_state_nx = S_IDLE;
                w_q_nx     = w_din[r_owner];
                w_ptr_nx   = wrap_idx(r_owner, 1);
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            r_state   <= S_IDLE;
            r_q       <= '0;
            r_gnt     <= '0;
            r_set_ack <= 1'b0;
            r_owner   <= '0;
            r_ptr     <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_q       <= w_q_nx;
            r_gnt     <= w_gnt_nx;
            r_set_ack <= w_set_ack_nx;
            r_owner   <= w_owner_nx;
            r_ptr     <= w_ptr_nx;
        end
    end

    assign set_ack = r_set_ack;
    assign gnt     = r_gnt;
    assign Q       = r_q;
    assign owner   = r_owner;
    assign busy    = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/ff_bank_arbiter.md
Name: ff_bank_arbiter

Overview:
Round-robin arbiter and sequencer for a shared WIDTH-bit register bank built from positive-edge, synchronous-set flip-flops. Up to NREQ requesters compete to load the bank; a separate set request presets the bank to all ones using the flops' synchronous set path. The block holds the bank internally, drives its contents on Q, and sits between producer logic and any consumer of the shared register.

Parameters:
WIDTH, 8, bit width of the shared register bank
NREQ, 4, number of write requesters (2..8); pointer width is clog2(NREQ)

Ports:
clk  input  1  rising-edge clock
R_n  input  1  asynchronous reset, active-low
set_req  input  1  level request to preset the bank to all ones; held until set_ack
set_ack  output  1  one-cycle pulse: preset performed at this edge
req  input  NREQ  per-requester write request, level; held until own gnt bit seen
din  input  NREQ*WIDTH  requester data, requester i on bits [i*WIDTH +: WIDTH]
gnt  output  NREQ  one-hot grant, high for exactly one cycle per write
Q  output  WIDTH  current bank contents
owner  output  clog2(NREQ)  index of the most recently granted requester
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (R_n=0, asynchronous): state=IDLE, Q=0, gnt=0, set_ack=0, owner=0, rr pointer=0, busy=0. All outputs are registered, so assertion mid-operation clears gnt/set_ack immediately and no write completes.
- FSM states: IDLE, SETTING, GRANT.
- IDLE, evaluated at each rising edge:
  - set_req=1 -> SETTING. Preset has priority over all writes.
  - else any req bit set -> GRANT; winner = first set bit searching from ptr upward, wrapping NREQ-1 -> 0. gnt[winner] and owner=winner are registered at this edge.
  - else remain in IDLE.
- SETTING lasts one cycle. The exiting edge loads Q to all ones and pulses set_ack for the following cycle. The next state is always IDLE.
- GRANT lasts one cycle with gnt[owner]=1. The exiting edge does the following:
  - loads Q <= din[owner] as sampled at that edge;
  - sets ptr <= owner+1 modulo NREQ;
  - clears gnt;
  - moves to IDLE.
- Timing: req sampled at edge k -> gnt high in cycle k..k+1 -> Q updated at edge k+1. Throughput is one write per 2 cycles; back-to-back writes from different requesters are spaced 2 cycles apart.
- Requester protocol:
  - Hold req and din stable until the edge at which gnt is sampled high.
  - Deassert req in the following cycle.
  - A req still high at the next IDLE evaluation is treated as a new request.
- Arbitration inputs:
  - set_req or req changes during SETTING or GRANT are ignored until the next IDLE evaluation.
  - A req dropped before it is granted is simply never granted; no error is flagged.
- Simultaneous set_req and req in IDLE: the preset is serviced first and the req waits. Worst case, a write follows 2 cycles later.
- Fairness: the rr pointer advances only on a grant. Presets do not move the pointer.
- Q is only modified in SETTING or GRANT exits; otherwise it holds its value.
- owner retains its last value while idle.

Test Plan:
1. Reset values: hold R_n=0 for 3 cycles with req=4'b1111 and set_req=1 -> Q=0x00, gnt=0, set_ack=0, busy=0 throughout.
2. Single write: req=4'b0100, din[2]=0xA5 -> gnt=4'b0100 for one cycle; Q=0xA5 one edge later; owner=2; ptr=3.
3. Round-robin order: from ptr=0, req=4'b1111 held with din i = 0x10+i, each requester drops req after its grant -> grants in order 0,1,2,3 at 2-cycle spacing; Q steps 0x10,0x11,0x12,0x13; ptr wraps to 0.
4. Priority: set_req=1 and req=4'b0001 (din 0x3C) in the same IDLE cycle -> set_ack pulses and Q=0xFF first; gnt[0] follows 2 cycles later and Q=0x3C; ptr unaffected by the preset.
5. Wrap fairness: ptr=3, req=4'b1001 -> grant goes to 3 first, then 0.
6. Reset mid-GRANT: pull R_n low while gnt=4'b0010 -> gnt drops asynchronously, Q=0x00, din[1] is never loaded; after R_n release with req[1] still high, it is granted normally.
